// File: rtl/data_memory.sv
// data_memory: data memory stage for a single-cycle RV32I datapath.
//
// Byte-addressed, little-endian array of DEPTH 32-bit words. Loads are
// combinational (sign/zero extended); stores commit at the rising edge
// with byte-lane enables. Misaligned, illegal-funct3 and out-of-range
// accesses are suppressed: nothing is written and rdata reads as zero.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset, clears every word
//   addr         byte address (ALU result)
//   wdata        store data (rs2)
//   mem_read     load request this cycle
//   mem_write    store request this cycle
//   funct3       000 B, 001 H, 010 W, 100 BU, 101 HU
//   rdata        extended load data (combinational)
//   misaligned   alignment or illegal-funct3 fault (combinational)
//   out_of_range address at or beyond DEPTH*4 (combinational)
module data_memory #(
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        out_of_range
);

    // Compare on 33 bits so the limit itself can never overflow.
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    logic [31:0] mem [DEPTH];

    logic                 active;
    logic                 bad;
    logic                 fault;
    logic [ADDR_BITS-1:0] widx;
    logic [31:0]          word;
    logic [7:0]           rbyte;
    logic [15:0]          rhalf;
    logic [3:0]           be;
    logic [31:0]          wlanes;

    assign active = mem_read | mem_write;
    assign widx   = addr[ADDR_BITS+1:2];
    assign word   = mem[widx];

    // Full-width compare: upper address bits never alias into range.
    assign out_of_range = active && ({1'b0, addr} >= LIMIT);

    always_comb begin
        bad = 1'b0;
        if ((funct3 == 3'b001 || funct3 == 3'b101) && addr[0])
            bad = 1'b1;
        if (funct3 == 3'b010 && addr[1:0] != 2'b00)
            bad = 1'b1;
        if (mem_read && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
            bad = 1'b1;
        if (mem_write && funct3 > 3'b010)
            bad = 1'b1;
    end

    assign misaligned = active && bad;
    assign fault      = misaligned | out_of_range;

    // Load path: reads pre-write contents, so read-before-write falls out.
    always_comb begin
        case (addr[1:0])
            2'd0:    rbyte = word[7:0];
            2'd1:    rbyte = word[15:8];
            2'd2:    rbyte = word[23:16];
            default: rbyte = word[31:24];
        endcase
        rhalf = addr[1] ? word[31:16] : word[15:0];
        rdata = 32'd0;
        if (mem_read && !fault) begin
            case (funct3)
                3'b000:  rdata = {{24{rbyte[7]}}, rbyte};
                3'b100:  rdata = {24'd0, rbyte};
                3'b001:  rdata = {{16{rhalf[15]}}, rhalf};
                3'b101:  rdata = {16'd0, rhalf};
                3'b010:  rdata = word;
                default: rdata = 32'd0;
            endcase
        end
    end

    // Store path: replicate data across lanes, enable only the addressed ones.
    always_comb begin
        be     = 4'b0000;
        wlanes = wdata;
        case (funct3)
            3'b000: begin
                be     = 4'b0001 << addr[1:0];
                wlanes = {4{wdata[7:0]}};
            end
            3'b001: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            3'b010: begin
                be     = 4'b1111;
                wlanes = wdata;
            end
            default: begin
                be     = 4'b0000;
                wlanes = wdata;
            end
        endcase
        if (!mem_write || fault)
            be = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 32'd0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (be[k])
                    mem[widx][8*k +: 8] <= wlanes[8*k +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    localparam int DEPTH = 64;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        misaligned;
    logic        out_of_range;

    data_memory #(.DEPTH(DEPTH), .ADDR_BITS(6)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .rdata(rdata), .misaligned(misaligned), .out_of_range(out_of_range)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        oor;
        logic        chk_rd;
        int          id;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [NBYTES];
    int         vectors = 0;
    int         errors  = 0;
    int         issued  = 0;

    // Reference: byte-array memory, access rules evaluated directly.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic wr, input logic [2:0] f);
        exp_t        e;
        logic        act, bad, oor, flt;
        int          nb;
        logic [31:0] val;
        @(posedge clk);
        #1;
        rst = r; addr = a; wdata = d; mem_read = rd; mem_write = wr; funct3 = f;

        act = rd || wr;
        nb  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        bad = 1'b0;
        if ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) bad = 1'b1;
        if (f == 3'd2 && (a % 4 != 0)) bad = 1'b1;
        if (rd && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) bad = 1'b1;
        if (wr && !(f inside {3'd0, 3'd1, 3'd2})) bad = 1'b1;
        oor = act && (a >= 32'(NBYTES));
        flt = (act && bad) || oor;

        val = 32'd0;
        if (rd && !flt) begin
            for (int i = 0; i < nb; i++)
                val = val | (32'(ref_mem[a + 32'(i)]) << (8 * i));
            if (!f[2] && nb < 4 && val[8*nb-1])
                val = val | (32'hFFFF_FFFF << (8 * nb));
        end

        e.rdata = val; e.mis = act && bad; e.oor = oor; e.chk_rd = rd; e.id = issued;
        issued++;
        sb.push_back(e);

        // State after the coming edge.
        if (r) begin
            for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'd0;
        end else if (wr && !flt) begin
            for (int i = 0; i < nb; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
        end
    endtask

    // Monitor: outputs are combinational, sample mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (misaligned !== e.mis || out_of_range !== e.oor ||
                (e.chk_rd && rdata !== e.rdata)) begin
                errors++;
                $display("FAIL vec%0d addr=%h f3=%b rd=%b wr=%b: got rdata=%h mis=%b oor=%b, want rdata=%h mis=%b oor=%b",
                         e.id, addr, funct3, mem_read, mem_write, rdata, misaligned,
                         out_of_range, e.rdata, e.mis, e.oor);
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; addr = 0; wdata = 0; mem_read = 0; mem_write = 0; funct3 = 0;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'd0;

        step(1, 0, 0, 0, 0, 0);
        // Reset clears stored data
        step(0, 0, 32'hDEADBEEF, 0, 1, 3'd2);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 3'd2);
        // Word round trip
        step(0, 8, 32'h12345678, 0, 1, 3'd2);
        step(0, 8, 0, 1, 0, 3'd2);
        step(0, 10, 0, 1, 0, 3'd5);
        step(0, 8, 0, 1, 0, 3'd0);
        // Bytes, halves, sign extension
        step(0, 13, 32'h000000AB, 0, 1, 3'd0);
        step(0, 12, 0, 1, 0, 3'd2);
        step(0, 13, 0, 1, 0, 3'd0);
        step(0, 13, 0, 1, 0, 3'd4);
        step(0, 14, 32'h00008001, 0, 1, 3'd1);
        step(0, 14, 0, 1, 0, 3'd1);
        step(0, 12, 0, 1, 0, 3'd2);
        // Misalignment / illegal funct3
        step(0, 4, 32'hCAFEF00D, 0, 1, 3'd2);
        step(0, 6, 32'hFFFFFFFF, 0, 1, 3'd2);
        step(0, 4, 0, 1, 0, 3'd2);
        step(0, 3, 0, 1, 0, 3'd1);
        step(0, 0, 0, 1, 0, 3'd3);
        step(0, 0, 32'h55, 0, 1, 3'd4);
        // Range boundary
        step(0, 252, 32'hA5A5A5A5, 0, 1, 3'd2);
        step(0, 252, 0, 1, 0, 3'd2);
        step(0, 256, 0, 1, 0, 3'd2);
        step(0, 0, 32'h01020304, 0, 1, 3'd2);
        step(0, 32'h100, 32'h99999999, 0, 1, 3'd2);
        step(0, 0, 0, 1, 0, 3'd2);
        step(0, 32'h8000_0000, 0, 1, 0, 3'd0);
        // Read-before-write
        step(0, 20, 32'h11111111, 0, 1, 3'd2);
        step(0, 20, 32'h22222222, 1, 1, 3'd2);
        step(0, 20, 0, 1, 0, 3'd2);
        // Idle
        step(0, 0, 0, 0, 0, 3'd7);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic        rd, wr;
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 7));
            rd = $urandom_range(0, 1) == 1;
            wr = $urandom_range(0, 2) == 0;
            step($urandom_range(0, 99) == 0, a, $urandom, rd, wr, 3'($urandom_range(0, 7)));
        end
        step(0, 0, 0, 0, 0, 0);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d vectors unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data memory stage directly downstream of the ALU in the single-cycle RISC-V datapath.
- The ALU result drives the byte address; register-file rs2 drives the store data.
- Implements RV32I loads (LB/LH/LW/LBU/LHU) with sign or zero extension, and stores (SB/SH/SW) with byte-lane writes.
- Detects misaligned, illegal and out-of-range accesses and suppresses them.

Parameters:
- DEPTH, 64, number of 32-bit words; must be a power of two, at least 4.
- ADDR_BITS, 6, log2(DEPTH); word-index width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  byte address, taken from the ALU result.
- wdata  input  32  store data (rs2).
- mem_read  input  1  load request this cycle.
- mem_write  input  1  store request this cycle.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdata  output  32  extended load data (combinational).
- misaligned  output  1  access fault: size/alignment or illegal funct3 (combinational).
- out_of_range  output  1  address at or beyond DEPTH*4 (combinational).

Behaviour:
- Storage: DEPTH x 32-bit words.
  - word index = addr[ADDR_BITS+1:2]; byte offset = addr[1:0].
  - Little-endian: byte k occupies bits [8k+7:8k].
- Reset: on a rising clk edge with rst=1, every word is cleared to 0. Any store in that cycle is dropped.
  - Outputs are combinational, so rdata, misaligned and out_of_range follow the current inputs and contents even during reset.
- Active access: mem_read=1 or mem_write=1.
  - With both low: rdata=0, misaligned=0, out_of_range=0, no write.
- out_of_range = active AND addr >= DEPTH*4. This uses the full 32-bit compare; no aliasing.
- misaligned = active AND any of:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- fault = misaligned OR out_of_range. A faulting access writes nothing and drives rdata=0.
- Loads: zero latency; rdata is combinational from the current array contents.
  - B: byte at offset, sign-extended from bit 7.
  - BU: same byte, zero-extended.
  - H: halfword at offset 0 or 2, sign-extended from bit 15.
  - HU: same halfword, zero-extended.
  - W: full word.
- Stores: commit at the rising edge, visible to a combinational read in the next cycle.
  - SB: writes wdata[7:0] to the addressed byte lane only.
  - SH: writes wdata[15:0] to lanes {0,1} or {2,3}.
  - SW: writes all four lanes.
  - Other lanes are preserved.
- mem_read and mem_write both high:
  - The store commits at the edge.
  - rdata shows the pre-write contents during that cycle (read-before-write), using the same funct3 for both.
- The address upper bits beyond ADDR_BITS+1 never wrap an access into range; the access faults instead.
- No internal state other than the array. The block has no stall or handshake; every access completes in one cycle.

Test Plan:
- Reset: write 0xDEADBEEF to addr 0, assert rst one cycle, then LW addr 0 -> rdata=0x00000000 and all flags 0.
- Word round trip: SW 0x12345678 at addr 8, next cycle LW addr 8 -> 0x12345678; LHU addr 10 -> 0x00001234; LB addr 8 -> 0x00000078.
- Byte and sign extension: SB 0xAB at addr 13 onto word 0 -> word 3 = 0x0000AB00.
  - LB addr 13 -> 0xFFFFFFAB; LBU addr 13 -> 0x000000AB.
  - SH 0x8001 at addr 14 -> LH addr 14 = 0xFFFF8001.
- Misalignment: SW 0xFFFFFFFF at addr 6 -> misaligned=1, no write (LW addr 4 unchanged).
  - LH addr 3 -> misaligned=1, rdata=0.
  - Load with funct3=011 -> misaligned=1.
- Range: with DEPTH=64, LW addr 252 -> valid; LW addr 256 -> out_of_range=1, rdata=0.
  - SW to addr 0x00000100 does not alter word 0.
- Simultaneous read/write: word 5 = 0x11111111; in one cycle SW 0x22222222 at addr 20 with mem_read=1 -> rdata=0x11111111 that cycle, 0x22222222 on the following cycle.
